lcd_hd44780_ctrl: RTL and testbench

Timing engine that sits directly downstream of the load/store unit's LCD control register output. It consumes the 32-bit LCD register word (address page 0x1000_4xxx) and turns each software-issued command into a correctly timed HD44780 bus cycle: setup, enable pulse, hold, then execution wait. Software no longer bit-bangs the enable line; it flips one "go" bit per command.

---
 rtl/lcd_hd44780_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 bus-cycle timing engine: turns each "go" toggle in the LCD register word
// into setup / enable pulse / hold / execution-wait. Optional read support: LCD_READ_EN.
module lcd_hd44780_ctrl #(
    parameter int unsigned SETUP_CYC     = 3,
    parameter int unsigned PULSE_CYC     = 12,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 80000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    input  logic [7:0]  i_lcd_data,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_data_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_rd_data,
    output logic        o_overrun
);

    localparam int unsigned LOG_W = $clog2(LONG_EXEC_CYC + 1);
    localparam int unsigned CNT_W = (LOG_W > 17) ? LOG_W : 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_go;
    logic               pend;
    logic [9:0]         pend_cmd;
    logic               toggle;
    logic               launch;
    logic               rw_in;
    logic               cmd_rw;
    logic               long_wait;
    logic [CNT_W-1:0]   wait_load;
    logic [9:0]         new_cmd;
    logic               unused_bits;

`ifdef LCD_READ_EN
    logic               rw_q;
    logic               oe_q;
    logic [7:0]         rd_q;

    assign rw_in         = i_io_lcd[8];
    assign cmd_rw        = rw_q;
    assign o_lcd_rw      = rw_q;
    assign o_lcd_data_oe = oe_q;
    assign o_rd_data     = rd_q;
    assign unused_bits   = ^i_io_lcd[30:11];
`else
    assign rw_in         = 1'b0;
    assign cmd_rw        = 1'b0;
    assign o_lcd_rw      = 1'b0;
    assign o_lcd_data_oe = 1'b1;
    assign o_rd_data     = 8'h00;
    assign unused_bits   = ^{i_io_lcd[30:11], i_io_lcd[8], i_lcd_data, pend_cmd[8]};
`endif

    assign toggle  = i_io_lcd[10] ^ last_go;
    assign launch  = (state == ST_IDLE) && pend;
    assign new_cmd = {i_io_lcd[9], rw_in, i_io_lcd[7:0]};
    assign o_busy  = pend | (state != ST_IDLE);

    // Clear (0x01) and home (0x02/0x03) need the long execution wait
    assign long_wait = !o_lcd_rs && !cmd_rw && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data != 8'd0);
    assign wait_load = long_wait ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_go    <= 1'b0;
            pend       <= 1'b0;
            pend_cmd   <= '0;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_done     <= 1'b0;
            o_overrun  <= 1'b0;
`ifdef LCD_READ_EN
            rw_q       <= 1'b0;
            oe_q       <= 1'b1;
            rd_q       <= 8'h00;
`endif
        end else begin
            last_go  <= i_io_lcd[10];
            o_lcd_on <= i_io_lcd[31];
            o_done   <= 1'b0;

            // A toggle arriving while the pending command launches simply re-arms pend
            if (launch) begin
                pend <= toggle;
                if (toggle) pend_cmd <= new_cmd;
            end else if (toggle) begin
                pend     <= 1'b1;
                pend_cmd <= new_cmd;
                if (pend) o_overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        state      <= ST_SETUP;
                        cnt        <= CNT_W'(SETUP_CYC - 1);
                        o_lcd_rs   <= pend_cmd[9];
                        o_lcd_data <= pend_cmd[7:0];
`ifdef LCD_READ_EN
                        rw_q       <= pend_cmd[8];
                        oe_q       <= ~pend_cmd[8];
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state    <= ST_PULSE;
                        cnt      <= CNT_W'(PULSE_CYC - 1);
                        o_lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state    <= ST_HOLD;
                        cnt      <= CNT_W'(HOLD_CYC - 1);
                        o_lcd_en <= 1'b0;
`ifdef LCD_READ_EN
                        if (rw_q) rd_q <= i_lcd_data;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state  <= ST_WAIT;
                        cnt    <= wait_load;
                        o_done <= (wait_load == '0);
`ifdef LCD_READ_EN
                        oe_q   <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // o_done lands on the final WAIT cycle
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) o_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: command scoreboard checked on each EN pulse and done.
module tb_lcd_hd44780_ctrl;

    localparam int unsigned SETUP = 3;
    localparam int unsigned PULSE = 12;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned EXEC  = 200;
    localparam int unsigned LONG  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_word;
    logic [7:0]  lcd_din;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_oe, busy, done, overrun;
    logic [7:0]  lcd_dout, rd_data;

    lcd_hd44780_ctrl #(
        .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
        .EXEC_CYC(EXEC), .LONG_EXEC_CYC(LONG)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_io_lcd(io_word), .i_lcd_data(lcd_din),
        .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
        .o_lcd_data(lcd_dout), .o_lcd_data_oe(lcd_oe), .o_busy(busy), .o_done(done),
        .o_rd_data(rd_data), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rs;
        logic        rw;
        logic [7:0]  data;
        logic [31:0] wait_len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   go = 1'b0;
    bit   on_bit = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic eff_rw(input logic rw);
`ifdef LCD_READ_EN
        return rw;
`else
        return 1'b0 & rw;
`endif
    endfunction

    function automatic logic [31:0] wait_of(input logic rs, input logic rw, input logic [7:0] d);
        return (!rs && !eff_rw(rw) && d[7:2] == 6'd0 && d != 8'd0) ? LONG : EXEC;
    endfunction

    task automatic send(input logic rs, input logic rw, input logic [7:0] d, input bit runs);
        exp_t e;
        go      = ~go;
        io_word = {on_bit, 20'd0, go, rs, rw, d};
        if (runs) begin
            e.rs = rs; e.rw = eff_rw(rw); e.data = d; e.wait_len = wait_of(rs, rw, d);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int limit, output int done_c);
        int n = 0;
        done_c = -1;
        while (busy && n < limit) begin
            if (done) done_c = cyc;
            tick();
            n++;
        end
        checks++;
        assert (!busy) else begin
            failures++;
            $error("FAIL idle_timeout observed=busy expected=idle within %0d", limit);
        end
    endtask

    task automatic wait_en(input int limit, output int rise_c);
        int n = 0;
        while (!lcd_en && n < limit) begin
            tick();
            n++;
        end
        rise_c = cyc;
        checks++;
        assert (lcd_en) else begin
            failures++;
            $error("FAIL en_timeout observed=0 expected=1 within %0d", limit);
        end
    endtask

    // Scoreboard monitor: command identity at EN rise, pulse width, done latency
    bit   prev_en = 1'b0;
    bit   active = 1'b0;
    int   en_cnt = 0;
    int   rise_cyc = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
            active  = 1'b0;
            en_cnt  = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_cmd observed=%0h expected=none", {lcd_rs, lcd_rw, lcd_dout});
                end
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    check("cmd_pins", {22'd0, lcd_rs, lcd_rw, lcd_dout}, {22'd0, cur.rs, cur.rw, cur.data});
                    check("data_oe", 32'(lcd_oe), 32'(!cur.rw));
                end
                rise_cyc = cyc;
                en_cnt = 0;
            end
            if (lcd_en) en_cnt++;
            if (!lcd_en && prev_en) check("en_width", en_cnt, PULSE);
            if (done) begin
                checks++;
                assert (active) else begin
                    failures++;
                    $error("FAIL spurious_done observed=1 expected=0");
                end
                if (active) check("done_latency", cyc - rise_cyc, PULSE + HOLD + cur.wait_len - 1);
                active = 1'b0;
            end
            prev_en = lcd_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d1, r2, done_c, activity;
        rst = 1'b1; io_word = 32'd0; lcd_din = 8'h00;
        repeat (3) tick();
        check("rst_en", 32'(lcd_en), 0);
        check("rst_rs", 32'(lcd_rs), 0);
        check("rst_rw", 32'(lcd_rw), 0);
        check("rst_data", 32'(lcd_dout), 0);
        check("rst_on", 32'(lcd_on), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd", 32'(rd_data), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_oe", 32'(lcd_oe), 1);
        rst = 1'b0;
        tick();

        // Function set 0x38
        send(1'b0, 1'b0, 8'h38, 1'b1);
        t0 = cyc;
        tick();
        check("busy_n1", 32'(busy), 1);
        check("pins_n1", 32'(lcd_dout), 0);
        tick();
        check("pins_n2", 32'(lcd_dout), 32'h38);
        check("en_n2", 32'(lcd_en), 0);
        wait_en(50, r2);
        check("en_rise_delay", r2 - t0, 2 + SETUP);
        wait_idle(5000, done_c);
        check("fs_done_cycle", done_c - t0, 2 + SETUP + PULSE + HOLD + EXEC - 1);
        check("fs_busy_fall", cyc - done_c, 1);
        check("fs_data_held", 32'(lcd_dout), 32'h38);

        // Clear display: long wait; same byte as data write: normal wait
        send(1'b0, 1'b0, 8'h01, 1'b1);
        t0 = cyc;
        tick();
        wait_idle(5000, done_c);
        check("clr_done_cycle", done_c - t0, 2 + SETUP + PULSE + HOLD + LONG - 1);
        send(1'b1, 1'b0, 8'h01, 1'b1);
        t0 = cyc;
        tick();
        wait_idle(5000, done_c);
        check("wr01_done_cycle", done_c - t0, 2 + SETUP + PULSE + HOLD + EXEC - 1);
        check("wr01_rs", 32'(lcd_rs), 1);

        // Command queued during WAIT runs right after
        send(1'b0, 1'b0, 8'h80, 1'b1);
        repeat (2 + SETUP + PULSE + HOLD + 10) tick();
        send(1'b0, 1'b0, 8'h0C, 1'b1);
        tick();
        d1 = -1;
        for (int n = 0; n < 5000 && d1 < 0; n++) begin
            if (done) d1 = cyc;
            else tick();
        end
        wait_en(50, r2);
        check("b2b_gap", r2 - d1, 2 + SETUP);
        wait_idle(5000, done_c);
        check("queued_overrun", 32'(overrun), 0);

        // Two toggles during one command: second overwrites first
        send(1'b0, 1'b0, 8'h28, 1'b1);
        repeat (10) tick();
        send(1'b0, 1'b0, 8'h0C, 1'b0);
        repeat (3) tick();
        send(1'b0, 1'b0, 8'h06, 1'b1);
        tick();
        check("overrun_set", 32'(overrun), 1);
        wait_idle(5000, done_c);
        check("last_data", 32'(lcd_dout), 32'h06);
        send(1'b0, 1'b0, 8'h14, 1'b1);
        tick();
        wait_idle(5000, done_c);
        check("overrun_sticky", 32'(overrun), 1);

        // Reset five cycles into EN high, with a pending command behind it
        send(1'b0, 1'b0, 8'h38, 1'b1);
        tick();
        wait_en(50, r2);
        send(1'b0, 1'b0, 8'h0C, 1'b0);
        repeat (4) tick();
        check("en_before_rst", 32'(lcd_en), 1);
        rst = 1'b1;
        exp_q.delete();
        go = 1'b0;
        io_word = 32'd0;
        #1;
        check("rst_async_en", 32'(lcd_en), 0);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_overrun", 32'(overrun), 0);
        tick();
        rst = 1'b0;
        activity = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (busy || lcd_en || done) activity++;
        end
        check("idle_after_rst", activity, 0);

        // Read command with panel driving 0xA5
        lcd_din = 8'hA5;
        send(1'b0, 1'b1, 8'h01, 1'b1);
        t0 = cyc;
        tick();
        tick();
`ifdef LCD_READ_EN
        check("rd_rw_pin", 32'(lcd_rw), 1);
        check("rd_oe_setup", 32'(lcd_oe), 0);
`else
        check("rd_rw_pin", 32'(lcd_rw), 0);
        check("rd_oe_setup", 32'(lcd_oe), 1);
`endif
        wait_idle(5000, done_c);
        check("rd_done_cycle", done_c - t0, 2 + SETUP + PULSE + HOLD + wait_of(1'b0, 1'b1, 8'h01) - 1);
`ifdef LCD_READ_EN
        check("rd_data", 32'(rd_data), 32'hA5);
`else
        check("rd_data", 32'(rd_data), 0);
`endif
        check("rd_oe_after", 32'(lcd_oe), 1);

        // Power bit without a toggle
        on_bit = 1'b1;
        io_word[31] = 1'b1;
        check("on_pre", 32'(lcd_on), 0);
        tick();
        check("on_post", 32'(lcd_on), 1);
        check("on_busy", 32'(busy), 0);
        repeat (5) tick();
        check("exp_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
